// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - operand fetch stage: register file, pending-write scoreboard, hazard stall, bypass
module operand_fetch_stage #(
    parameter int          DATA_W     = 64,
    parameter int          NREGS      = 16,
    parameter int          RA_W       = 4,
    parameter int          PC_W       = 4,
    parameter int          INSTR_W    = 16,
    parameter logic [15:0] MATH_MASK  = 16'h00F0,
    parameter logic [15:0] WRITE_MASK = 16'h0100
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [INSTR_W-1:0]         in_instr,
    input  logic                       wb_en,
    input  logic [RA_W-1:0]            wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [3:0]                 out_opcode,
    output logic [DATA_W-1:0]          out_rs1_data,
    output logic [DATA_W-1:0]          out_rs2_data,
    output logic                       out_rs1_zero,
    output logic [INSTR_W-4-RA_W-1:0]  out_address,
    output logic [RA_W-1:0]            out_dest,
    output logic                       out_writes
);

    localparam int ADDR_W = INSTR_W - 4 - RA_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  sb_q, sb_d;

    logic              out_valid_q, out_valid_d;
    logic [PC_W-1:0]   out_pc_q, out_pc_d;
    logic [3:0]        out_opcode_q, out_opcode_d;
    logic [DATA_W-1:0] out_rs1_data_q, out_rs1_data_d;
    logic [DATA_W-1:0] out_rs2_data_q, out_rs2_data_d;
    logic              out_rs1_zero_q, out_rs1_zero_d;
    logic [ADDR_W-1:0] out_address_q, out_address_d;
    logic [RA_W-1:0]   out_dest_q, out_dest_d;
    logic              out_writes_q, out_writes_d;

    logic [3:0]        opcode;
    logic [RA_W-1:0]   rs1, rs2, rd, dest;
    logic [ADDR_W-1:0] address;
    logic              math, writes;
    logic              wb_hit1, wb_hit2, hazard, accept;
    logic [DATA_W-1:0] rs1_data, rs2_data;

    always_comb begin
        opcode  = in_instr[3:0];
        rs1     = in_instr[3+RA_W:4];
        rs2     = in_instr[3+2*RA_W:4+RA_W];
        rd      = in_instr[3+3*RA_W:4+2*RA_W];
        address = in_instr[INSTR_W-1:4+RA_W];
        math    = MATH_MASK[opcode];
        writes  = math | WRITE_MASK[opcode];
        dest    = math ? rd : rs1;

        wb_hit1  = wb_en && (wb_addr == rs1);
        wb_hit2  = wb_en && (wb_addr == rs2);
        rs1_data = wb_hit1 ? wb_data : regs_q[rs1];
        rs2_data = wb_hit2 ? wb_data : regs_q[rs2];

        // A pending source being retired by writeback this cycle is satisfied via bypass
        hazard   = (sb_q[rs1] && !wb_hit1) || (math && sb_q[rs2] && !wb_hit2);
        in_ready = !hazard && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
    end

    always_comb begin
        sb_d = sb_q;
        for (int i = 0; i < NREGS; i++) begin
            if (accept && writes && (dest == RA_W'(i))) begin
                sb_d[i] = 1'b1;
            end else if (wb_en && (wb_addr == RA_W'(i))) begin
                sb_d[i] = 1'b0;
            end
        end

        regs_d = regs_q;
        if (wb_en) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    always_comb begin
        out_valid_d    = out_valid_q;
        out_pc_d       = out_pc_q;
        out_opcode_d   = out_opcode_q;
        out_rs1_data_d = out_rs1_data_q;
        out_rs2_data_d = out_rs2_data_q;
        out_rs1_zero_d = out_rs1_zero_q;
        out_address_d  = out_address_q;
        out_dest_d     = out_dest_q;
        out_writes_d   = out_writes_q;
        if (accept) begin
            out_valid_d    = 1'b1;
            out_pc_d       = in_pc;
            out_opcode_d   = opcode;
            out_rs1_data_d = rs1_data;
            out_rs2_data_d = rs2_data;
            out_rs1_zero_d = (rs1_data == '0);
            out_address_d  = address;
            out_dest_d     = dest;
            out_writes_d   = writes;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            sb_q           <= '0;
            out_valid_q    <= 1'b0;
            out_pc_q       <= '0;
            out_opcode_q   <= '0;
            out_rs1_data_q <= '0;
            out_rs2_data_q <= '0;
            out_rs1_zero_q <= 1'b0;
            out_address_q  <= '0;
            out_dest_q     <= '0;
            out_writes_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            sb_q           <= sb_d;
            out_valid_q    <= out_valid_d;
            out_pc_q       <= out_pc_d;
            out_opcode_q   <= out_opcode_d;
            out_rs1_data_q <= out_rs1_data_d;
            out_rs2_data_q <= out_rs2_data_d;
            out_rs1_zero_q <= out_rs1_zero_d;
            out_address_q  <= out_address_d;
            out_dest_q     <= out_dest_d;
            out_writes_q   <= out_writes_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_opcode   = out_opcode_q;
    assign out_rs1_data = out_rs1_data_q;
    assign out_rs2_data = out_rs2_data_q;
    assign out_rs1_zero = out_rs1_zero_q;
    assign out_address  = out_address_q;
    assign out_dest     = out_dest_q;
    assign out_writes   = out_writes_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - directed and random checks of operand_fetch_stage against a behavioural model
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_pc = '0;
    logic [15:0] in_instr = '0;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_addr = '0;
    logic [63:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_pc;
    logic [3:0]  out_opcode;
    logic [63:0] out_rs1_data;
    logic [63:0] out_rs2_data;
    logic        out_rs1_zero;
    logic [7:0]  out_address;
    logic [3:0]  out_dest;
    logic        out_writes;

    int errors = 0;
    int checks = 0;

    operand_fetch_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rs1_zero(out_rs1_zero),
        .out_address(out_address), .out_dest(out_dest), .out_writes(out_writes)
    );

    always #5 clk = ~clk;

    // Architectural model: register values, pending destinations, the bundle held for execute
    logic [63:0] m_regs [16];
    bit          m_pend [16];
    logic        m_ov = 0;
    logic [3:0]  m_pc = 0, m_op = 0, m_dest = 0;
    logic [63:0] m_r1 = 0, m_r2 = 0;
    logic        m_z = 0, m_wr = 0;
    logic [7:0]  m_addr = 0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] mk(input int op, input int s1, input int s2, input int d);
        logic [15:0] v;
        v = {d[3:0], s2[3:0], s1[3:0], op[3:0]};
        return v;
    endfunction

    function automatic bit is_math(input logic [3:0] op);
        return (op >= 4 && op <= 7);
    endfunction

    function automatic bit is_load(input logic [3:0] op);
        return (op == 8);
    endfunction

    function automatic logic [63:0] value_of(input logic [3:0] r);
        if (wb_en && wb_addr == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic bit waiting_on(input logic [3:0] r);
        return m_pend[r] && !(wb_en && wb_addr == r);
    endfunction

    function automatic bit exp_ready();
        logic [3:0] op, s1, s2;
        bit stall;
        op = in_instr[3:0];
        s1 = in_instr[7:4];
        s2 = in_instr[11:8];
        stall = waiting_on(s1) || (is_math(op) && waiting_on(s2));
        return !stall && (!m_ov || out_ready);
    endfunction

    // Compare DUT against the model each cycle, then advance the model with the inputs the next edge will see
    always @(negedge clk) begin
        bit          rdy, acc, wr;
        logic [3:0]  op, d;
        logic [63:0] a, b;
        rdy = exp_ready();
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, m_ov);
        chk("out_pc", out_pc, m_pc);
        chk("out_opcode", out_opcode, m_op);
        chk("out_rs1_data", out_rs1_data, m_r1);
        chk("out_rs2_data", out_rs2_data, m_r2);
        chk("out_rs1_zero", out_rs1_zero, m_z);
        chk("out_address", out_address, m_addr);
        chk("out_dest", out_dest, m_dest);
        chk("out_writes", out_writes, m_wr);
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 0;
            end
            m_ov = 0; m_pc = 0; m_op = 0; m_r1 = 0; m_r2 = 0;
            m_z = 0; m_addr = 0; m_dest = 0; m_wr = 0;
        end else begin
            acc = in_valid && rdy;
            op  = in_instr[3:0];
            wr  = is_math(op) || is_load(op);
            d   = is_math(op) ? in_instr[15:12] : in_instr[7:4];
            a   = value_of(in_instr[7:4]);
            b   = value_of(in_instr[11:8]);
            if (acc) begin
                m_ov = 1; m_pc = in_pc; m_op = op; m_r1 = a; m_r2 = b;
                m_z = (a == 0); m_addr = in_instr[15:8]; m_dest = d; m_wr = wr;
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
            if (wb_en) begin
                m_pend[wb_addr] = 0;
                m_regs[wb_addr] = wb_data;
            end
            if (acc && wr) m_pend[d] = 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        cyc(); cyc();
        reset = 0;
        // Load R3, R4, then math op reading both
        wb_en = 1; wb_addr = 3; wb_data = 64'h5; cyc();
        wb_addr = 4; wb_data = 64'h7; cyc();
        wb_en = 0; out_ready = 1; in_valid = 1; in_instr = mk(4, 3, 4, 9); in_pc = 1;
        cyc();
        in_instr = mk(8, 9, 0, 0); in_pc = 2;
        @(negedge clk);
        chk("t1_valid", out_valid, 1);
        chk("t1_rs1", out_rs1_data, 64'h5);
        chk("t1_rs2", out_rs2_data, 64'h7);
        chk("t1_dest", out_dest, 9);
        chk("t1_writes", out_writes, 1);
        chk("raw_stall0", in_ready, 0);
        cyc();
        @(negedge clk);
        chk("raw_stall1", in_ready, 0);
        cyc();
        wb_en = 1; wb_addr = 9; wb_data = 64'h11;
        @(negedge clk);
        chk("raw_release", in_ready, 1);
        cyc();
        wb_en = 0; in_valid = 0;
        @(negedge clk);
        chk("raw_data", out_rs1_data, 64'h11);
        chk("raw_dest", out_dest, 9);
        // Same-cycle bypass
        cyc();
        wb_en = 1; wb_addr = 2; wb_data = 64'hAA;
        in_valid = 1; in_instr = mk(5, 2, 3, 5); in_pc = 4;
        @(negedge clk);
        chk("byp_ready", in_ready, 1);
        cyc();
        wb_en = 0; out_ready = 0; in_instr = mk(4, 3, 4, 6); in_pc = 5;
        @(negedge clk);
        chk("byp_data", out_rs1_data, 64'hAA);
        chk("bp_ready0", in_ready, 0);
        // Backpressure holds output stable
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            chk("bp_ready", in_ready, 0);
            chk("bp_pc", out_pc, 4);
        end
        cyc();
        out_ready = 1;
        @(negedge clk);
        chk("bp_release", in_ready, 1);
        cyc();
        in_instr = 16'hBA08; in_pc = 6;
        @(negedge clk);
        chk("bp_next_pc", out_pc, 5);
        chk("bp_next_rs2", out_rs2_data, 64'h7);
        // Load from R0 with zero flag
        cyc();
        in_valid = 0; out_ready = 0;
        @(negedge clk);
        chk("ld_zero", out_rs1_zero, 1);
        chk("ld_dest", out_dest, 0);
        chk("ld_addr", out_address, 8'hBA);
        chk("ld_writes", out_writes, 1);
        // Reset with bundle held and R9 pending; writeback in same cycle is ignored
        cyc();
        reset = 1; wb_en = 1; wb_addr = 9; wb_data = 64'h33;
        cyc();
        reset = 0; wb_en = 0;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_rs1", out_rs1_data, 0);
        cyc();
        in_valid = 1; in_instr = mk(8, 9, 0, 0); out_ready = 1;
        @(negedge clk);
        chk("rst_nostall", in_ready, 1);
        cyc();
        in_valid = 0;
        @(negedge clk);
        chk("rst_r9", out_rs1_data, 0);
        chk("rst_r9_valid", out_valid, 1);
        // Random traffic checked by the model
        for (int n = 0; n < 400; n++) begin
            logic [3:0] ops [6];
            ops = '{4'd1, 4'd4, 4'd5, 4'd7, 4'd8, 4'd8};
            cyc();
            reset     = ($urandom_range(0, 59) == 0);
            in_valid  = $urandom_range(0, 1);
            in_instr  = {$urandom_range(0, 15) & 4'hF, $urandom_range(0, 15) & 4'hF,
                         $urandom_range(0, 15) & 4'hF, ops[$urandom_range(0, 5)]};
            in_pc     = $urandom_range(0, 15);
            wb_en     = ($urandom_range(0, 2) != 0);
            wb_addr   = $urandom_range(0, 15);
            wb_data   = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) wb_data = '0;
            out_ready = ($urandom_range(0, 3) != 0);
        end
        cyc();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Parametrised operand-fetch pipeline stage, sitting between instruction fetch and execute.
- Holds the architectural register file and a pending-write scoreboard.
- Stalls on read-after-write hazards with in-flight destinations, and bypasses same-cycle writeback data.
- Presents a registered operand bundle to execute over a valid/ready handshake.

Parameters:
- DATA_W, 64, register/operand width.
- NREGS, 16, number of registers (power of 2).
- RA_W, 4, register index width, equal to log2(NREGS).
- PC_W, 4, program counter width.
- INSTR_W, 16, instruction width; must be at least 4+3*RA_W.
- MATH_MASK, 16'h00F0, bit n set means opcode n is arithmetic (dest=rd field, reads rs1 and rs2).
- WRITE_MASK, 16'h0100, bit n set means non-math opcode n writes register rs1 (load).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_pc  in  PC_W  PC of the instruction.
- in_instr  in  INSTR_W  fields: [3:0] opcode, [3+RA_W:4] rs1, [3+2RA_W:4+RA_W] rs2, [3+3RA_W:4+2RA_W] rd; address = [INSTR_W-1:4+RA_W].
- wb_en  in  1  writeback write enable.
- wb_addr  in  RA_W  writeback register index.
- wb_data  in  DATA_W  writeback data.
- out_valid  out  1  bundle valid.
- out_ready  in  1  execute accepts.
- out_pc  out  PC_W  registered PC.
- out_opcode  out  4  registered opcode.
- out_rs1_data  out  DATA_W  operand 1.
- out_rs2_data  out  DATA_W  operand 2.
- out_rs1_zero  out  1  operand 1 equals zero (branch flag).
- out_address  out  INSTR_W-4-RA_W  immediate/address field.
- out_dest  out  RA_W  register to be written.
- out_writes  out  1  instruction writes out_dest.

Behaviour:
- On reset:
  - All registers clear to 0 and all scoreboard bits clear.
  - out_valid=0; all out_* data fields=0.
  - reset dominates a same-cycle wb_en or in_valid.
- Decode (combinational on in_instr):
  - math = MATH_MASK[opcode]; dest = math ? rd : rs1; writes = math | WRITE_MASK[opcode].
  - rs1 is always a source; rs2 is a source only if math.
- Read bypass: if wb_en and wb_addr equals a source index, that operand takes wb_data in the same cycle.
- Hazard:
  - hazard = source register has its scoreboard bit set and is not being cleared by wb_en/wb_addr this cycle.
  - Register 0 is an ordinary register, not hardwired.
- in_ready = !hazard && (!out_valid || out_ready).
- Accept: a transfer occurs when in_valid && in_ready.
  - Output register loads the bypassed operands, pc, opcode, address, dest and writes.
  - out_valid is set to 1.
  - Latency: 1 cycle from accept to out_valid.
- Drain: out_valid && out_ready with no accept clears out_valid. Output fields hold their last values while out_valid=0 or while stalled.
- Scoreboard, per-register next state:
  - set if accepted && writes && dest==i;
  - else clear if wb_en && wb_addr==i;
  - else hold.
  - Set wins over a same-cycle clear of the same register.
- Register file write: on wb_en, regs[wb_addr] <= wb_data, independent of handshake and stall.
- Backpressure: while out_valid && !out_ready, in_ready=0 and the output is stable (AXI-style: valid is never dropped without a handshake).
- Reset mid-stall drops the in-flight bundle and all pending scoreboard entries.

Test Plan:
- reset, then wb writes R3=0x5 and R4=0x7; issue math opcode 4 with rs1=3, rs2=4, rd=9 -> next cycle out_valid=1, rs1=0x5, rs2=0x7, out_dest=9, out_writes=1, scoreboard[9]=1.
- Same-cycle bypass: wb_en R2=0xAA together with an issue reading rs1=2 -> out_rs1_data=0xAA, no stall.
- RAW stall: issue writing R9, then an instruction reading R9 -> in_ready=0 until wb_en R9=0x11; in that same cycle the instruction accepts and gets 0x11.
- Backpressure: out_ready=0 for 3 cycles with in_valid held -> in_ready=0 and out_* stable; out_ready=1 -> next instruction accepted the following edge.
- Zero flag/load: opcode 8 with rs1=0 and R0=0 -> out_rs1_zero=1, out_dest=0, out_address=instr[15:8].
- Reset while scoreboard[9]=1 and out_valid=1 -> next cycle out_valid=0, scoreboard clear, a read of R9 returns 0 with no stall.
